// File: rtl/ethercat_timer_pkg.sv
// rtl/ethercat_timer_pkg.sv - register map and CTRL/STAT bit positions for ethercat_timer_mc
package ethercat_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_CMP    = 2'd2,
    REG_SNAP   = 2'd3
  } reg_sel_e;

  localparam int CTRL_TO_IE     = 0;
  localparam int CTRL_CONT      = 1;
  localparam int CTRL_START     = 2;
  localparam int CTRL_STOP      = 3;
  localparam int CTRL_CMP_IE    = 4;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int ST_TO   = 16;
  localparam int ST_CMPF = 17;
  localparam int ST_RUN  = 18;

endpackage

// File: rtl/ethercat_timer_ch.sv
// rtl/ethercat_timer_ch.sv - one timer channel: prescaler, down-counter, flags, pulses, PWM
module ethercat_timer_ch
  import ethercat_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49_999_999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr,
  input  logic [1:0]  i_reg,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic        o_timeout_pulse,
  output logic        o_cmp_pulse,
  output logic        o_pwm
);

  localparam logic [CNT_W-1:0] L_RST_PERIOD = CNT_W'(RESET_PERIOD);

  logic               r_to_ie, r_cont, r_cmp_ie, r_to, r_cmpf, r_run;
  logic [PRESC_W-1:0] r_presc, r_pcnt;
  logic [CNT_W-1:0]   r_period, r_cmp, r_snap, r_count;
  logic               r_to_pulse, r_cmp_pulse;
  logic               w_tick, w_to_evt, w_cmp_evt, w_ctrl_wr;
  logic               w_unused_wdata;

  assign w_tick         = r_run && (r_pcnt == r_presc);
  assign w_to_evt       = w_tick && (r_count == '0);
  assign w_cmp_evt      = w_tick && (r_count == r_cmp);
  assign w_ctrl_wr      = i_wr && (reg_sel_e'(i_reg) == REG_CTRL);
  assign w_unused_wdata = &{1'b0, i_wdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_ie     <= 1'b0;
      r_cont      <= 1'b0;
      r_cmp_ie    <= 1'b0;
      r_presc     <= '0;
      r_pcnt      <= '0;
      r_period    <= L_RST_PERIOD;
      r_count     <= L_RST_PERIOD;
      r_cmp       <= '0;
      r_snap      <= '0;
      r_to        <= 1'b0;
      r_cmpf      <= 1'b0;
      r_run       <= 1'b0;
      r_to_pulse  <= 1'b0;
      r_cmp_pulse <= 1'b0;
    end else begin
      r_to_pulse  <= w_to_evt;
      r_cmp_pulse <= w_cmp_evt;
      // Event set has priority over write-one-to-clear on the same edge
      r_to   <= w_to_evt  | (r_to   & ~(w_ctrl_wr & i_wdata[ST_TO]));
      r_cmpf <= w_cmp_evt | (r_cmpf & ~(w_ctrl_wr & i_wdata[ST_CMPF]));

      if (!r_run || w_tick) r_pcnt <= '0;
      else                  r_pcnt <= r_pcnt + 1'b1;

      if (w_tick) begin
        if (r_count == '0) begin
          r_count <= r_period;
          if (!r_cont) r_run <= 1'b0;
        end else begin
          r_count <= r_count - 1'b1;
        end
      end

      // Register writes come last so they override counter activity in the same cycle
      if (i_wr) begin
        case (reg_sel_e'(i_reg))
          REG_CTRL: begin
            r_to_ie  <= i_wdata[CTRL_TO_IE];
            r_cont   <= i_wdata[CTRL_CONT];
            r_cmp_ie <= i_wdata[CTRL_CMP_IE];
            r_presc  <= i_wdata[CTRL_PRESC_LSB +: PRESC_W];
            if (i_wdata[CTRL_START]) begin
              r_run  <= 1'b1;
              r_pcnt <= '0;
            end else if (i_wdata[CTRL_STOP]) begin
              r_run  <= 1'b0;
            end
          end
          REG_PERIOD: begin
            r_period <= i_wdata[CNT_W-1:0];
            r_count  <= i_wdata[CNT_W-1:0];
            r_run    <= 1'b0;
          end
          REG_CMP:  r_cmp  <= i_wdata[CNT_W-1:0];
          REG_SNAP: r_snap <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (reg_sel_e'(i_reg))
      REG_CTRL: begin
        o_rdata[CTRL_TO_IE]                  = r_to_ie;
        o_rdata[CTRL_CONT]                   = r_cont;
        o_rdata[CTRL_CMP_IE]                 = r_cmp_ie;
        o_rdata[CTRL_PRESC_LSB +: PRESC_W]   = r_presc;
        o_rdata[ST_TO]                       = r_to;
        o_rdata[ST_CMPF]                     = r_cmpf;
        o_rdata[ST_RUN]                      = r_run;
      end
      REG_PERIOD: o_rdata = 32'(r_period);
      REG_CMP:    o_rdata = 32'(r_cmp);
      REG_SNAP:   o_rdata = 32'(r_snap);
    endcase
  end

  assign o_irq           = (r_to & r_to_ie) | (r_cmpf & r_cmp_ie);
  assign o_timeout_pulse = r_to_pulse;
  assign o_cmp_pulse     = r_cmp_pulse;
  assign o_pwm           = r_run && (r_count < r_cmp);

endmodule

// File: rtl/ethercat_timer_mc.sv
// rtl/ethercat_timer_mc.sv - multi-channel interval timer on an Avalon-MM slave
module ethercat_timer_mc
  import ethercat_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESC_W      = 8,
  parameter int RESET_PERIOD = 49_999_999
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+1:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          timeout_pulse,
  output logic [NUM_CH-1:0]          cmp_pulse,
  output logic [NUM_CH-1:0]          pwm_out
);

  logic [3:0]        w_ch;
  logic              w_wr;
  logic [NUM_CH-1:0] w_irq;
  logic [31:0]       w_ch_rdata [NUM_CH];
  logic [31:0]       w_rdata;

  assign w_ch = 4'(address >> 2);
  assign w_wr = chipselect && !write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ethercat_timer_ch #(
      .CNT_W        (CNT_W),
      .PRESC_W      (PRESC_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk             (clk),
      .reset_n         (reset_n),
      .i_wr            (w_wr && (w_ch == 4'(g))),
      .i_reg           (address[1:0]),
      .i_wdata         (writedata),
      .o_rdata         (w_ch_rdata[g]),
      .o_irq           (w_irq[g]),
      .o_timeout_pulse (timeout_pulse[g]),
      .o_cmp_pulse     (cmp_pulse[g]),
      .o_pwm           (pwm_out[g])
    );
  end

  // Channel indices beyond NUM_CH fall through to zero
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 4'(i)) w_rdata = w_ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

  assign irq = |w_irq;

endmodule

// File: tb/tb_ethercat_timer_mc.sv
// tb/tb_ethercat_timer_mc.sv - directed self-checking bench for ethercat_timer_mc
module tb_ethercat_timer_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  timeout_pulse, cmp_pulse, pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  ethercat_timer_mc #(
    .NUM_CH (4), .CNT_W (32), .PRESC_W (8), .RESET_PERIOD (49_999_999)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq),
    .timeout_pulse (timeout_pulse),
    .cmp_pulse     (cmp_pulse),
    .pwm_out       (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    address    = 4'((ch << 2) | rg);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int rg, output logic [31:0] d);
    address    = 4'((ch << 2) | rg);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    d          = readdata;
  endtask

  task automatic wait_pulse(input int ch, input bit is_cmp, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound && n < 0; k++) begin
      @(posedge clk); #1;
      if (is_cmp ? cmp_pulse[ch] : timeout_pulse[ch]) n = k;
    end
  endtask

  initial begin
    logic [31:0] d;
    int n, n_pwm, n_cmp, first_cmp;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {17'd0, irq, timeout_pulse, cmp_pulse, pwm_out}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1. reset values
    rd(0, 1, d); check("t1_period", d, 32'h02FA_F07F);
    rd(0, 0, d); check("t1_ctrl", d, 32'd0);
    check("t1_outs", {17'd0, irq, timeout_pulse, cmp_pulse, pwm_out}, 32'd0);

    // 2. ch1 continuous, PRESC=1, PERIOD=9 -> 20 clks per timeout
    wr(1, 1, 32'd9);
    wr(1, 0, 32'h0000_0106);
    wait_pulse(1, 1'b0, 100, n); check("t2_first_to", 32'(n), 32'd20);
    wait_pulse(1, 1'b0, 100, n); check("t2_second_to", 32'(n), 32'd20);
    rd(1, 0, d); check("t2_ctrl", d, 32'h0007_0102);
    check("t2_irq_off", {31'd0, irq}, 32'd0);
    wr(1, 0, 32'h0000_0103);
    check("t2_irq_on", {31'd0, irq}, 32'd1);
    wr(1, 0, 32'h0001_0103);
    check("t2_irq_w1c", {31'd0, irq}, 32'd0);
    wr(1, 0, 32'h0000_0008);

    // 3. ch2 PWM / compare, PERIOD=7, COMPARE=3
    wr(2, 1, 32'd7);
    wr(2, 2, 32'd3);
    wr(2, 0, 32'h0000_0006);
    n_pwm = 0; n_cmp = 0; first_cmp = -1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (pwm_out[2]) n_pwm++;
      if (cmp_pulse[2]) begin
        n_cmp++;
        if (first_cmp < 0) first_cmp = k;
      end
    end
    check("t3_pwm_high", 32'(n_pwm), 32'd6);
    check("t3_cmp_count", 32'(n_cmp), 32'd2);
    check("t3_cmp_first", 32'(first_cmp), 32'd5);
    wr(2, 0, 32'h0000_0008);
    check("t3_pwm_stop", {31'd0, pwm_out[2]}, 32'd0);

    // COMPARE > PERIOD: never matches, PWM stays high while running
    wr(2, 1, 32'd5);
    wr(2, 2, 32'd9);
    wr(2, 0, 32'h0000_0006);
    n_pwm = 0; n_cmp = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (pwm_out[2]) n_pwm++;
      if (cmp_pulse[2]) n_cmp++;
    end
    check("t3_big_cmp_pwm", 32'(n_pwm), 32'd12);
    check("t3_big_cmp_none", 32'(n_cmp), 32'd0);
    wr(2, 0, 32'h0000_0008);

    // 4. ch0 one-shot, PERIOD=4
    wr(0, 1, 32'd4);
    wr(0, 0, 32'h0000_0004);
    wait_pulse(0, 1'b0, 50, n); check("t4_to_at", 32'(n), 32'd5);
    wait_pulse(0, 1'b0, 30, n); check("t4_no_second", 32'(n), 32'hFFFF_FFFF);
    rd(0, 0, d); check("t4_ctrl", d, 32'h0003_0000);
    wr(0, 3, 32'd0);
    rd(0, 3, d); check("t4_snap_count", d, 32'd4);

    // PERIOD=0 continuous: timeout on every tick
    wr(0, 1, 32'd0);
    wr(0, 0, 32'h0000_0006);
    wait_pulse(0, 1'b0, 10, n); check("t4_p0_first", 32'(n), 32'd1);
    wait_pulse(0, 1'b0, 10, n); check("t4_p0_next", 32'(n), 32'd1);
    wr(0, 0, 32'h0000_0008);

    // 5. PERIOD write mid-run, snapshot, START+STOP
    wr(3, 1, 32'd100);
    wr(3, 0, 32'h0000_0006);
    repeat (5) @(posedge clk);
    #1;
    wr(3, 1, 32'd50);
    rd(3, 0, d); check("t5_run_clr", d, 32'h0000_0002);
    wr(3, 3, 32'd0);
    rd(3, 3, d); check("t5_snap", d, 32'd50);
    wr(3, 0, 32'h0000_000E);
    rd(3, 0, d); check("t5_start_stop", d, 32'h0004_0002);

    // 6. W1C on the same edge as a timeout event
    wr(3, 1, 32'd3);
    wr(3, 0, 32'h0000_0006);
    repeat (7) @(posedge clk);
    #1;
    wr(3, 0, 32'h0001_0002);
    rd(3, 0, d); check("t6_w1c_vs_evt", d, 32'h0007_0002);
    wr(3, 0, 32'h0001_0002);
    rd(3, 0, d); check("t6_w1c_plain", d, 32'h0006_0002);

    // Asynchronous reset mid-count
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_outs", {17'd0, irq, timeout_pulse, cmp_pulse, pwm_out}, 32'd0);
    check("t6_rst_rdata", readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (timeout_pulse != 4'd0 || cmp_pulse != 4'd0 || pwm_out != 4'd0 || irq) n++;
    end
    check("t6_no_pulse", 32'(n), 32'd0);
    rd(3, 0, d); check("t6_ctrl_rst", d, 32'd0);
    rd(3, 1, d); check("t6_period_rst", d, 32'h02FA_F07F);
    rd(1, 0, d); check("t6_ch1_rst", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
